// File: rtl/ysyx_25020047_ifu_fetch.sv
// ysyx_25020047_ifu_fetch: instruction fetch stage, one outstanding imem request, redirect-aware bundle delivery to decode
module ysyx_25020047_ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [31:0]      imem_addr,
  input  logic             imem_resp_valid,
  output logic             imem_resp_ready,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_resp_err,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst,
  output logic [31:0]      inst_pc,
  output logic [31:0]      inst_snpc,
  output logic [1:0]       inst_fault,
  output logic [CNT_W-1:0] fetch_cnt
);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_FLUSH, S_OUT} state_t;
  state_t state;
  logic [31:0] pc, ra, pc_n;
  logic pend, redir, misal;
  always_comb begin
    redir = redirect_valid && state != S_IDLE;
    misal = ra[1:0] != 2'd0;
    pc_n = redir ? redirect_pc : (state == S_OUT && inst_ready) ? pc + 32'd4 : pc;
  end
  assign imem_req_valid  = state == S_REQ && !misal;
  assign imem_addr       = ra;
  assign imem_resp_ready = state == S_WAIT || state == S_FLUSH;
  assign inst_valid      = state == S_OUT;
  // ra always reloads from the pc value being written on the same edge, so the latest redirect wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      ra         <= '0;
      pend       <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      inst_snpc  <= '0;
      inst_fault <= '0;
      fetch_cnt  <= '0;
    end else begin
      pc <= pc_n;
      case (state)
        S_IDLE: begin
          state <= S_REQ;
          ra    <= pc;
        end
        S_REQ:
          if (misal) begin
            if (redir) ra <= pc_n;
            else begin
              inst       <= '0;
              inst_fault <= 2'd2;
              inst_pc    <= ra;
              inst_snpc  <= ra + 32'd4;
              state      <= S_OUT;
            end
          end else if (imem_req_ready) begin
            state <= (pend || redir) ? S_FLUSH : S_WAIT;
            pend  <= 1'b0;
          end else if (redir) pend <= 1'b1;
        S_WAIT:
          if (imem_resp_valid) begin
            if (redir) begin
              state <= S_REQ;
              ra    <= pc_n;
            end else begin
              inst       <= imem_resp_err ? '0 : imem_rdata;
              inst_fault <= {1'b0, imem_resp_err};
              inst_pc    <= ra;
              inst_snpc  <= ra + 32'd4;
              state      <= S_OUT;
            end
          end else if (redir) state <= S_FLUSH;
        S_FLUSH:
          if (imem_resp_valid) begin
            state <= S_REQ;
            ra    <= pc_n;
          end
        S_OUT:
          if (inst_ready || redir) begin
            state <= S_REQ;
            ra    <= pc_n;
            if (inst_ready) fetch_cnt <= fetch_cnt + CNT_W'(1);
          end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
